// File: rtl/bank_timing_scheduler.sv
// bank_timing_scheduler
//   Per-bank DRAM timing guard placed between the command decoder and the PHY
//   command issue stage. Tracks open/closed state of every bank plus the
//   tRCD/tRAS/tRP/tWR/tRFC/tCCD_L/tCCD_S windows and only accepts a command
//   (cmd_valid & cmd_ready) when it is legal at that moment.
// Ports
//   sys_clk      clock
//   sys_rst      synchronous reset, active high
//   cmd_valid    command offered this cycle
//   cmd_decoded  0=NOP 1=REF 2=ACT 3=PRE 4=RD 5=WR, 6..15 illegal
//   bank_group   target bank group
//   bank         target bank within group
//   cmd_ready    combinational: offered command is legal now (low in reset)
//   bank_open    registered: bit i set while bank {bank_group,bank}=i is ACTIVE
//   err_illegal  registered one-cycle pulse after an illegal code was offered
module bank_timing_scheduler #(
  parameter int unsigned BG_BITS = 2,
  parameter int unsigned BA_BITS = 2,
  parameter int unsigned CNT_W   = 8,
  parameter int unsigned T_RFC   = 50,
  parameter int unsigned T_RCD   = 18,
  parameter int unsigned T_RAS   = 32,
  parameter int unsigned T_RP    = 18,
  parameter int unsigned T_WTP   = 20,
  parameter int unsigned T_CCD_L = 6,
  parameter int unsigned T_CCD_S = 4
) (
  input  logic                              sys_clk,
  input  logic                              sys_rst,
  input  logic                              cmd_valid,
  input  logic [3:0]                        cmd_decoded,
  input  logic [BG_BITS-1:0]                bank_group,
  input  logic [BA_BITS-1:0]                bank,
  output logic                              cmd_ready,
  output logic [2**(BG_BITS+BA_BITS)-1:0]   bank_open,
  output logic                              err_illegal
);

  localparam int unsigned BANK_W = BG_BITS + BA_BITS;
  localparam int unsigned NBANKS = 2**BANK_W;

  typedef enum logic [3:0] {
    CMD_NOP = 4'd0,
    CMD_REF = 4'd1,
    CMD_ACT = 4'd2,
    CMD_PRE = 4'd3,
    CMD_RD  = 4'd4,
    CMD_WR  = 4'd5
  } cmd_e;

  if (((T_RFC >> CNT_W) != 0) || ((T_RCD >> CNT_W) != 0) || ((T_RAS >> CNT_W) != 0) ||
      ((T_RP >> CNT_W) != 0) || ((T_WTP >> CNT_W) != 0) || ((T_CCD_L >> CNT_W) != 0) ||
      ((T_CCD_S >> CNT_W) != 0)) begin : g_timing_range_check
    $error("bank_timing_scheduler: a T_* value does not fit in CNT_W bits");
  end

  // A window of T cycles loads T-1 so the follow-on command is legal exactly T cycles later.
  function automatic logic [CNT_W-1:0] load_of(input int unsigned t);
    return (t == 0) ? '0 : CNT_W'(t - 1);
  endfunction

  function automatic logic [CNT_W-1:0] dec(input logic [CNT_W-1:0] v);
    return (v == '0) ? '0 : v - CNT_W'(1);
  endfunction

  localparam logic [CNT_W-1:0] LD_RFC  = load_of(T_RFC);
  localparam logic [CNT_W-1:0] LD_RCD  = load_of(T_RCD);
  localparam logic [CNT_W-1:0] LD_RAS  = load_of(T_RAS);
  localparam logic [CNT_W-1:0] LD_RP   = load_of(T_RP);
  localparam logic [CNT_W-1:0] LD_WTP  = load_of(T_WTP);
  localparam logic [CNT_W-1:0] LD_CCDL = load_of(T_CCD_L);
  localparam logic [CNT_W-1:0] LD_CCDS = load_of(T_CCD_S);

  logic [BANK_W-1:0]  idx;
  logic               accept;
  logic               is_rdwr;
  logic               ccd_clear;
  logic [NBANKS-1:0]  bank_quiet;   // IDLE and rp_cnt == 0
  logic [NBANKS-1:0]  rcd_zero;
  logic [NBANKS-1:0]  ras_zero;

  logic [CNT_W-1:0]   ccdl_q, ccdl_d;
  logic [CNT_W-1:0]   ccds_q, ccds_d;
  logic [BG_BITS-1:0] last_bg_q, last_bg_d;
  logic               err_illegal_q, err_illegal_d;

  assign idx         = {bank_group, bank};
  assign accept      = cmd_valid && cmd_ready;
  assign is_rdwr     = (cmd_decoded == CMD_RD) || (cmd_decoded == CMD_WR);
  assign err_illegal = err_illegal_q;

  for (genvar g = 0; g < NBANKS; g++) begin : g_bank
    logic             hit;
    logic             open_q, open_d;
    logic [CNT_W-1:0] rcd_q, rcd_d;
    logic [CNT_W-1:0] ras_q, ras_d;
    logic [CNT_W-1:0] rp_q, rp_d;

    assign hit           = accept && (idx == BANK_W'(g));
    assign bank_open[g]  = open_q;
    assign bank_quiet[g] = !open_q && (rp_q == '0);
    assign rcd_zero[g]   = (rcd_q == '0);
    assign ras_zero[g]   = (ras_q == '0);

    always_comb begin
      open_d = open_q;
      rcd_d  = dec(rcd_q);
      ras_d  = dec(ras_q);
      rp_d   = dec(rp_q);
      if (accept && (cmd_decoded == CMD_REF)) begin
        rp_d = LD_RFC;
      end
      if (hit) begin
        case (cmd_decoded)
          CMD_ACT: begin
            open_d = 1'b1;
            rcd_d  = LD_RCD;
            ras_d  = LD_RAS;
          end
          CMD_PRE: begin
            if (open_q) begin
              open_d = 1'b0;
              rp_d   = LD_RP;
            end
          end
          // Write recovery only extends the PRE window; compare against the
          // already-decremented value so the ACT->PRE window is not stretched.
          CMD_WR: begin
            if (ras_d < LD_WTP) begin
              ras_d = LD_WTP;
            end
          end
          default: ;
        endcase
      end
    end

    always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
        open_q <= 1'b0;
        rcd_q  <= '0;
        ras_q  <= '0;
        rp_q   <= '0;
      end else begin
        open_q <= open_d;
        rcd_q  <= rcd_d;
        ras_q  <= ras_d;
        rp_q   <= rp_d;
      end
    end
  end

  assign ccd_clear = (bank_group == last_bg_q) ? (ccdl_q == '0) : (ccds_q == '0);

  always_comb begin
    cmd_ready = 1'b0;
    case (cmd_decoded)
      CMD_NOP: cmd_ready = 1'b1;
      CMD_REF: cmd_ready = &bank_quiet;
      CMD_ACT: cmd_ready = bank_quiet[idx];
      CMD_PRE: cmd_ready = !bank_open[idx] || ras_zero[idx];
      CMD_RD,
      CMD_WR:  cmd_ready = bank_open[idx] && rcd_zero[idx] && ccd_clear;
      default: cmd_ready = 1'b0;
    endcase
    if (sys_rst) begin
      cmd_ready = 1'b0;
    end
  end

  always_comb begin
    ccdl_d        = dec(ccdl_q);
    ccds_d        = dec(ccds_q);
    last_bg_d     = last_bg_q;
    err_illegal_d = cmd_valid && (cmd_decoded > CMD_WR);
    if (accept && is_rdwr) begin
      ccdl_d    = LD_CCDL;
      ccds_d    = LD_CCDS;
      last_bg_d = bank_group;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      ccdl_q        <= '0;
      ccds_q        <= '0;
      last_bg_q     <= '0;
      err_illegal_q <= 1'b0;
    end else begin
      ccdl_q        <= ccdl_d;
      ccds_q        <= ccds_d;
      last_bg_q     <= last_bg_d;
      err_illegal_q <= err_illegal_d;
    end
  end

endmodule

// File: tb/tb_bank_timing_scheduler.sv
// tb_bank_timing_scheduler
//   Scenario tasks drive the scheduler and check cmd_ready, bank_open and
//   err_illegal against expectations queued when the stimulus is applied.
module tb_bank_timing_scheduler;

  localparam logic [3:0] NOP = 4'd0;
  localparam logic [3:0] REF = 4'd1;
  localparam logic [3:0] ACT = 4'd2;
  localparam logic [3:0] PRE = 4'd3;
  localparam logic [3:0] RD  = 4'd4;
  localparam logic [3:0] WR  = 4'd5;

  logic        sys_clk = 1'b0;
  logic        sys_rst;
  logic        cmd_valid;
  logic [3:0]  cmd_decoded;
  logic [1:0]  bank_group;
  logic [1:0]  bank;
  logic        cmd_ready;
  logic [15:0] bank_open;
  logic        err_illegal;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  logic        rdy_exp_q[$];
  logic [15:0] open_exp_q[$];
  logic        err_exp_q[$];

  bank_timing_scheduler #(
    .BG_BITS(2), .BA_BITS(2), .CNT_W(8),
    .T_RFC(50), .T_RCD(18), .T_RAS(32), .T_RP(18),
    .T_WTP(20), .T_CCD_L(6), .T_CCD_S(4)
  ) dut (
    .sys_clk(sys_clk),
    .sys_rst(sys_rst),
    .cmd_valid(cmd_valid),
    .cmd_decoded(cmd_decoded),
    .bank_group(bank_group),
    .bank(bank),
    .cmd_ready(cmd_ready),
    .bank_open(bank_open),
    .err_illegal(err_illegal)
  );

  always #5 sys_clk = ~sys_clk;

  // Inputs change on the falling edge; outputs are read 1 time unit later.
  task automatic set_in(input logic v, input logic [3:0] c, input logic [3:0] b);
    @(negedge sys_clk);
    cmd_valid   = v;
    cmd_decoded = c;
    {bank_group, bank} = b;
    #1;
  endtask

  task automatic idle(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) set_in(1'b0, NOP, 4'd0);
  endtask

  task automatic apply_reset();
    @(negedge sys_clk);
    sys_rst   = 1'b1;
    cmd_valid = 1'b0;
    cmd_decoded = NOP;
    {bank_group, bank} = 4'd0;
    repeat (2) @(negedge sys_clk);
    sys_rst = 1'b0;
  endtask

  task automatic test_reset();
    logic        e;
    logic [15:0] ev;
    @(negedge sys_clk);
    sys_rst = 1'b1; cmd_valid = 1'b1; cmd_decoded = ACT; {bank_group, bank} = 4'd3;
    #1;
    rdy_exp_q.push_back(1'b0);
    e = rdy_exp_q.pop_front(); n_checks++;
    if (cmd_ready !== e) begin n_fail++; $display("FAIL reset_ready_low cmd_ready=%b expected=%b", cmd_ready, e); end
    open_exp_q.push_back(16'h0000);
    err_exp_q.push_back(1'b0);
    @(negedge sys_clk); #1;
    ev = open_exp_q.pop_front(); n_checks++;
    if (bank_open !== ev) begin n_fail++; $display("FAIL reset_bank_open bank_open=%h expected=%h", bank_open, ev); end
    e = err_exp_q.pop_front(); n_checks++;
    if (err_illegal !== e) begin n_fail++; $display("FAIL reset_err err_illegal=%b expected=%b", err_illegal, e); end
    @(negedge sys_clk);
    sys_rst = 1'b0; cmd_valid = 1'b0; cmd_decoded = ACT;
    #1;
    rdy_exp_q.push_back(1'b1);
    e = rdy_exp_q.pop_front(); n_checks++;
    if (cmd_ready !== e) begin n_fail++; $display("FAIL first_cycle_act cmd_ready=%b expected=%b", cmd_ready, e); end
    cmd_decoded = REF;
    #1;
    rdy_exp_q.push_back(1'b1);
    e = rdy_exp_q.pop_front(); n_checks++;
    if (cmd_ready !== e) begin n_fail++; $display("FAIL first_cycle_ref cmd_ready=%b expected=%b", cmd_ready, e); end
  endtask

  task automatic test_rcd();
    logic        e;
    logic [15:0] ev;
    apply_reset();
    set_in(1'b1, ACT, 4'd5);
    rdy_exp_q.push_back(1'b1);
    open_exp_q.push_back(16'h0020);
    e = rdy_exp_q.pop_front(); n_checks++;
    if (cmd_ready !== e) begin n_fail++; $display("FAIL act_bank5 cmd_ready=%b expected=%b", cmd_ready, e); end
    for (int k = 1; k <= 18; k++) begin
      set_in(1'b0, RD, 4'd5);
      if (k == 1) begin
        ev = open_exp_q.pop_front(); n_checks++;
        if (bank_open !== ev) begin n_fail++; $display("FAIL act_bank_open bank_open=%h expected=%h", bank_open, ev); end
      end
      rdy_exp_q.push_back(k >= 18);
      e = rdy_exp_q.pop_front(); n_checks++;
      if (cmd_ready !== e) begin n_fail++; $display("FAIL rcd_window k=%0d cmd_ready=%b expected=%b", k, cmd_ready, e); end
    end
    set_in(1'b0, RD, 4'd6);
    rdy_exp_q.push_back(1'b0);
    e = rdy_exp_q.pop_front(); n_checks++;
    if (cmd_ready !== e) begin n_fail++; $display("FAIL rd_closed_bank cmd_ready=%b expected=%b", cmd_ready, e); end
  endtask

  task automatic test_ras_rp();
    logic        e;
    logic [15:0] ev;
    apply_reset();
    set_in(1'b1, ACT, 4'd0);
    open_exp_q.push_back(16'h0001);
    for (int k = 1; k <= 32; k++) begin
      set_in(1'b1, PRE, 4'd0);
      if (k == 1) begin
        ev = open_exp_q.pop_front(); n_checks++;
        if (bank_open !== ev) begin n_fail++; $display("FAIL ras_bank_open bank_open=%h expected=%h", bank_open, ev); end
      end
      rdy_exp_q.push_back(k == 32);
      e = rdy_exp_q.pop_front(); n_checks++;
      if (cmd_ready !== e) begin n_fail++; $display("FAIL ras_window k=%0d cmd_ready=%b expected=%b", k, cmd_ready, e); end
    end
    open_exp_q.push_back(16'h0000);
    for (int j = 1; j <= 18; j++) begin
      set_in(1'b0, ACT, 4'd0);
      if (j == 1) begin
        ev = open_exp_q.pop_front(); n_checks++;
        if (bank_open !== ev) begin n_fail++; $display("FAIL pre_bank_closed bank_open=%h expected=%h", bank_open, ev); end
      end
      rdy_exp_q.push_back(j >= 18);
      e = rdy_exp_q.pop_front(); n_checks++;
      if (cmd_ready !== e) begin n_fail++; $display("FAIL rp_window j=%0d cmd_ready=%b expected=%b", j, cmd_ready, e); end
    end
    set_in(1'b0, PRE, 4'd9);
    rdy_exp_q.push_back(1'b1);
    e = rdy_exp_q.pop_front(); n_checks++;
    if (cmd_ready !== e) begin n_fail++; $display("FAIL pre_idle_bank cmd_ready=%b expected=%b", cmd_ready, e); end
  endtask

  task automatic test_ccd();
    logic e;
    apply_reset();
    set_in(1'b1, ACT, 4'd0);
    set_in(1'b1, ACT, 4'd1);
    set_in(1'b1, ACT, 4'd4);
    idle(20);
    set_in(1'b1, RD, 4'd0);
    rdy_exp_q.push_back(1'b1);
    e = rdy_exp_q.pop_front(); n_checks++;
    if (cmd_ready !== e) begin n_fail++; $display("FAIL rd_bank0 cmd_ready=%b expected=%b", cmd_ready, e); end
    for (int k = 1; k <= 6; k++) begin
      set_in(1'b0, RD, 4'd1);
      rdy_exp_q.push_back(k >= 6);
      e = rdy_exp_q.pop_front(); n_checks++;
      if (cmd_ready !== e) begin n_fail++; $display("FAIL ccd_l k=%0d cmd_ready=%b expected=%b", k, cmd_ready, e); end
    end
    idle(8);
    set_in(1'b1, RD, 4'd0);
    for (int k = 1; k <= 4; k++) begin
      set_in(1'b0, RD, 4'd4);
      rdy_exp_q.push_back(k >= 4);
      e = rdy_exp_q.pop_front(); n_checks++;
      if (cmd_ready !== e) begin n_fail++; $display("FAIL ccd_s k=%0d cmd_ready=%b expected=%b", k, cmd_ready, e); end
    end
  endtask

  task automatic test_ref();
    logic e;
    apply_reset();
    set_in(1'b1, ACT, 4'd7);
    set_in(1'b0, REF, 4'd0);
    rdy_exp_q.push_back(1'b0);
    e = rdy_exp_q.pop_front(); n_checks++;
    if (cmd_ready !== e) begin n_fail++; $display("FAIL ref_bank_open cmd_ready=%b expected=%b", cmd_ready, e); end
    idle(30);
    set_in(1'b1, PRE, 4'd7);
    rdy_exp_q.push_back(1'b1);
    e = rdy_exp_q.pop_front(); n_checks++;
    if (cmd_ready !== e) begin n_fail++; $display("FAIL ref_pre_bank7 cmd_ready=%b expected=%b", cmd_ready, e); end
    for (int k = 1; k <= 18; k++) begin
      set_in(k == 18, REF, 4'd0);
      rdy_exp_q.push_back(k >= 18);
      e = rdy_exp_q.pop_front(); n_checks++;
      if (cmd_ready !== e) begin n_fail++; $display("FAIL ref_after_pre k=%0d cmd_ready=%b expected=%b", k, cmd_ready, e); end
    end
    for (int k = 1; k <= 50; k++) begin
      logic [3:0] b;
      b = 4'(k % 16);
      set_in(1'b0, ACT, b);
      rdy_exp_q.push_back(k >= 50);
      e = rdy_exp_q.pop_front(); n_checks++;
      if (cmd_ready !== e) begin n_fail++; $display("FAIL rfc_window k=%0d bank=%0d cmd_ready=%b expected=%b", k, b, cmd_ready, e); end
    end
  endtask

  task automatic test_wtp();
    logic e;
    apply_reset();
    set_in(1'b1, ACT, 4'd2);
    idle(17);
    set_in(1'b1, WR, 4'd2);
    rdy_exp_q.push_back(1'b1);
    e = rdy_exp_q.pop_front(); n_checks++;
    if (cmd_ready !== e) begin n_fail++; $display("FAIL wr_at_trcd cmd_ready=%b expected=%b", cmd_ready, e); end
    for (int k = 19; k <= 38; k++) begin
      set_in(1'b0, PRE, 4'd2);
      rdy_exp_q.push_back(k >= 38);
      e = rdy_exp_q.pop_front(); n_checks++;
      if (cmd_ready !== e) begin n_fail++; $display("FAIL wtp_window k=%0d cmd_ready=%b expected=%b", k, cmd_ready, e); end
    end
  endtask

  task automatic test_illegal_reset();
    logic        e;
    logic [15:0] ev;
    apply_reset();
    set_in(1'b1, 4'd9, 4'd3);
    err_exp_q.push_back(1'b1);
    rdy_exp_q.push_back(1'b0);
    e = rdy_exp_q.pop_front(); n_checks++;
    if (cmd_ready !== e) begin n_fail++; $display("FAIL illegal_ready cmd_ready=%b expected=%b", cmd_ready, e); end
    set_in(1'b0, 4'd15, 4'd3);
    e = err_exp_q.pop_front(); n_checks++;
    if (err_illegal !== e) begin n_fail++; $display("FAIL err_pulse err_illegal=%b expected=%b", err_illegal, e); end
    err_exp_q.push_back(1'b0);
    set_in(1'b0, NOP, 4'd0);
    e = err_exp_q.pop_front(); n_checks++;
    if (err_illegal !== e) begin n_fail++; $display("FAIL err_one_cycle err_illegal=%b expected=%b", err_illegal, e); end
    set_in(1'b1, REF, 4'd0);
    idle(10);
    set_in(1'b0, ACT, 4'd3);
    rdy_exp_q.push_back(1'b0);
    e = rdy_exp_q.pop_front(); n_checks++;
    if (cmd_ready !== e) begin n_fail++; $display("FAIL act_mid_rfc cmd_ready=%b expected=%b", cmd_ready, e); end
    @(negedge sys_clk);
    sys_rst = 1'b1; cmd_valid = 1'b0;
    #1;
    rdy_exp_q.push_back(1'b0);
    e = rdy_exp_q.pop_front(); n_checks++;
    if (cmd_ready !== e) begin n_fail++; $display("FAIL ready_in_reset cmd_ready=%b expected=%b", cmd_ready, e); end
    @(negedge sys_clk);
    sys_rst = 1'b0; cmd_valid = 1'b1; cmd_decoded = ACT; {bank_group, bank} = 4'd3;
    #1;
    rdy_exp_q.push_back(1'b1);
    open_exp_q.push_back(16'h0008);
    e = rdy_exp_q.pop_front(); n_checks++;
    if (cmd_ready !== e) begin n_fail++; $display("FAIL act_after_reset cmd_ready=%b expected=%b", cmd_ready, e); end
    set_in(1'b0, NOP, 4'd0);
    ev = open_exp_q.pop_front(); n_checks++;
    if (bank_open !== ev) begin n_fail++; $display("FAIL open_after_reset bank_open=%h expected=%h", bank_open, ev); end
  endtask

  initial begin
    sys_rst     = 1'b1;
    cmd_valid   = 1'b0;
    cmd_decoded = NOP;
    bank_group  = 2'd0;
    bank        = 2'd0;
    test_reset();
    test_rcd();
    test_ras_rp();
    test_ccd();
    test_ref();
    test_wtp();
    test_illegal_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

endmodule
